// File: rtl/sy_ppl_fet_ibuf.sv
// Fetch-stage instruction buffer: circular FIFO feeding decode over a vld/rdy handshake.
// Optional SY_IBUF_BYPASS_EN macro enables a 0-cycle empty-buffer bypass from fetch to decode.
module sy_ppl_fet_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AWTH  = 32,
    parameter int unsigned IWTH  = 32,
    parameter int unsigned EWTH  = 6,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             fet_ibuf__vld_i,
    output logic             ibuf_fet__rdy_o,
    input  logic [AWTH-1:0]  fet_ibuf__pc_i,
    input  logic [AWTH-1:0]  fet_ibuf__npc_i,
    input  logic [IWTH-1:0]  fet_ibuf__instr_i,
    input  logic             fet_ibuf__is_c_i,
    input  logic [EWTH-1:0]  fet_ibuf__excp_i,
    output logic             fet_dec__vld_o,
    input  logic             dec_fet__rdy_i,
    output logic [AWTH-1:0]  fet_dec__pc_o,
    output logic [AWTH-1:0]  fet_dec__npc_o,
    output logic [IWTH-1:0]  fet_dec__instr_o,
    output logic             fet_dec__is_compressed_o,
    output logic [EWTH-1:0]  fet_dec__excp_o,
    output logic [PTR_W-1:0] ibuf_cnt_o
);

    localparam int unsigned IDX_W = PTR_W - 1;
    localparam int unsigned ENT_W = 2 * AWTH + IWTH + 1 + EWTH;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_adv;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);

    assign ibuf_fet__rdy_o = ~full;
    assign push   = fet_ibuf__vld_i & ~full & ~flush_i;
    assign in_ent = {fet_ibuf__pc_i, fet_ibuf__npc_i, fet_ibuf__instr_i,
                     fet_ibuf__is_c_i, fet_ibuf__excp_i};

`ifdef SY_IBUF_BYPASS_EN
    logic byp;
    // A bypassed entry that decode takes immediately never touches storage.
    assign byp            = empty & fet_ibuf__vld_i & ~flush_i & ~rst_i;
    assign fet_dec__vld_o = (~empty & ~flush_i) | byp;
    assign head           = byp ? in_ent : mem[rd_idx];
    assign pop            = fet_dec__vld_o & dec_fet__rdy_i;
    assign wr_en          = push & ~(byp & dec_fet__rdy_i);
    assign rd_adv         = pop & ~byp;
`else
    assign fet_dec__vld_o = ~empty & ~flush_i;
    assign head           = mem[rd_idx];
    assign pop            = fet_dec__vld_o & dec_fet__rdy_i;
    assign wr_en          = push;
    assign rd_adv         = pop;
`endif

    assign {fet_dec__pc_o, fet_dec__npc_o, fet_dec__instr_o,
            fet_dec__is_compressed_o, fet_dec__excp_o} = head;

    assign ibuf_cnt_o = wr_ptr - rd_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en);
            rd_ptr <= rd_ptr + PTR_W'(rd_adv);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= in_ent;
        end
    end

endmodule

// File: tb/tb_sy_ppl_fet_ibuf.sv
// Self-checking bench for sy_ppl_fet_ibuf: queue-based reference model plus directed literal checks.
// Honours SY_IBUF_BYPASS_EN when it is defined for the build.
module tb_sy_ppl_fet_ibuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AWTH  = 32;
    localparam int unsigned IWTH  = 32;
    localparam int unsigned EWTH  = 6;
    localparam int unsigned PTR_W = 3;
`ifdef SY_IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [AWTH-1:0] pc;
        logic [AWTH-1:0] npc;
        logic [IWTH-1:0] instr;
        logic            is_c;
        logic [EWTH-1:0] excp;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             vld_i = 1'b0;
    logic             rdy_i = 1'b0;
    logic [AWTH-1:0]  pc_i = '0;
    logic [AWTH-1:0]  npc_i = '0;
    logic [IWTH-1:0]  instr_i = '0;
    logic             is_c_i = 1'b0;
    logic [EWTH-1:0]  excp_i = '0;
    logic             rdy_o;
    logic             vld_o;
    logic [AWTH-1:0]  pc_o;
    logic [AWTH-1:0]  npc_o;
    logic [IWTH-1:0]  instr_o;
    logic             is_c_o;
    logic [EWTH-1:0]  excp_o;
    logic [PTR_W-1:0] cnt_o;

    int errors = 0;
    int checks = 0;
    ent_t q[$];

    sy_ppl_fet_ibuf #(.DEPTH(DEPTH), .AWTH(AWTH), .IWTH(IWTH), .EWTH(EWTH)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .flush_i                  (flush),
        .fet_ibuf__vld_i          (vld_i),
        .ibuf_fet__rdy_o          (rdy_o),
        .fet_ibuf__pc_i           (pc_i),
        .fet_ibuf__npc_i          (npc_i),
        .fet_ibuf__instr_i        (instr_i),
        .fet_ibuf__is_c_i         (is_c_i),
        .fet_ibuf__excp_i         (excp_i),
        .fet_dec__vld_o           (vld_o),
        .dec_fet__rdy_i           (rdy_i),
        .fet_dec__pc_o            (pc_o),
        .fet_dec__npc_o           (npc_o),
        .fet_dec__instr_o         (instr_o),
        .fet_dec__is_compressed_o (is_c_o),
        .fet_dec__excp_o          (excp_o),
        .ibuf_cnt_o               (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_byp();
        return BYP && (q.size() == 0) && vld_i && !flush && !rst;
    endfunction

    // Reference model: a queue of accepted entries, advanced on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit full_now;
            bit byp_now;
            bit vld_now;
            ent_t e;
            full_now = (q.size() == DEPTH);
            byp_now  = model_byp();
            vld_now  = (q.size() > 0) || byp_now;
            e.pc = pc_i; e.npc = npc_i; e.instr = instr_i; e.is_c = is_c_i; e.excp = excp_i;
            if (!(byp_now && rdy_i)) begin
                if (vld_now && rdy_i) q.delete(0);
                if (vld_i && !full_now) q.push_back(e);
            end
        end
    end

    // Compare process: every cycle, mid-way between the input drive point and the next edge.
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            chk("rst_vld", vld_o, 0);
            chk("rst_rdy", rdy_o, 1);
            chk("rst_cnt", cnt_o, 0);
            chk("rst_pc", pc_o, 0);
        end else begin
            bit byp_now;
            bit exp_vld;
            ent_t h;
            byp_now = model_byp();
            exp_vld = ((q.size() > 0) && !flush) || byp_now;
            chk("m_vld", vld_o, exp_vld);
            chk("m_rdy", rdy_o, q.size() != DEPTH);
            chk("m_cnt", cnt_o, q.size());
            if (exp_vld) begin
                if (byp_now) begin
                    h.pc = pc_i; h.npc = npc_i; h.instr = instr_i; h.is_c = is_c_i; h.excp = excp_i;
                end else begin
                    h = q[0];
                end
                chk("m_pc", pc_o, h.pc);
                chk("m_npc", npc_o, h.npc);
                chk("m_instr", instr_o, h.instr);
                chk("m_is_c", is_c_o, h.is_c);
                chk("m_excp", excp_o, h.excp);
            end
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [AWTH-1:0] pc, input logic r, input logic f);
        vld_i = v; pc_i = pc; npc_i = pc + 4; rdy_i = r; flush = f;
        instr_i = {pc[15:0], 16'h0013}; is_c_i = 1'b0; excp_i = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Fill to DEPTH with decode stalled, reject a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h1000 + 32'(4 * i), 0, 0);
            next();
        end
        drv(1, 32'h1010, 0, 0);
        #2;
        chk("fill_cnt", cnt_o, 4);
        chk("fill_rdy", rdy_o, 0);
        next();
        chk("fill_reject", cnt_o, 4);
        drv(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("drain_pc", pc_o, 32'h1000 + 32'(4 * i));
            chk("drain_cnt", cnt_o, 4 - i);
            if (i == 1) chk("drain_rdy", rdy_o, 1);
            next();
        end
        #2;
        chk("drained_cnt", cnt_o, 0);
        chk("drained_vld", vld_o, 0);
        next();

        // Steady push+pop at occupancy 2; pointers wrap repeatedly.
        drv(1, 32'h1100, 0, 0); next();
        drv(1, 32'h1104, 0, 0); next();
        for (int k = 0; k < 10; k++) begin
            drv(1, 32'h1108 + 32'(4 * k), 1, 0);
            #2;
            chk("pp_cnt", cnt_o, 2);
            chk("pp_pc", pc_o, 32'h1100 + 32'(4 * k));
            next();
        end
        drv(0, 0, 1, 0); next(); next();

        // Flush with a concurrent push: nothing survives, later push emerges first.
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h1200 + 32'(4 * i), 0, 0);
            next();
        end
        drv(1, 32'h2000, 0, 1);
        #2;
        chk("flush_vld", vld_o, 0);
        next();
        drv(0, 0, 0, 0);
        #2;
        chk("flush_cnt", cnt_o, 0);
        chk("flush_vld2", vld_o, 0);
        next();
        drv(1, 32'h3000, 1, 0);
        #2;
        if (BYP) begin
            chk("post_flush_byp_vld", vld_o, 1);
            chk("post_flush_byp_pc", pc_o, 32'h3000);
        end
        next();
        drv(0, 0, 1, 0);
        #2;
        if (!BYP) begin
            chk("post_flush_vld", vld_o, 1);
            chk("post_flush_pc", pc_o, 32'h3000);
        end
        next(); next();
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h2100 + 32'(4 * i), 0, 1);
            next();
        end
        drv(0, 0, 0, 0);
        #2;
        chk("held_flush_cnt", cnt_o, 0);
        next();

        // Compressed instruction with a fetch exception passes through bit-exact.
        drv(1, 32'h4000, 0, 0);
        instr_i = 32'h0000_4501; is_c_i = 1'b1; excp_i = 6'h2C;
        next();
        drv(1, 32'h4002, 0, 0); next();
        drv(0, 0, 1, 0);
        #2;
        chk("exc_instr", instr_o, 32'h4501);
        chk("exc_is_c", is_c_o, 1);
        chk("exc_excp", excp_o, 6'h2C);
        chk("exc_pc", pc_o, 32'h4000);
        next();
        #2;
        chk("exc_order_pc", pc_o, 32'h4002);
        chk("exc_order_is_c", is_c_o, 0);
        next(); next();

        // Empty buffer, decode ready: bypass latency versus stored latency.
        drv(1, 32'h5000, 1, 0);
        #2;
        chk("byp_vld", vld_o, BYP);
        if (BYP) chk("byp_pc", pc_o, 32'h5000);
        chk("byp_cnt", cnt_o, 0);
        next();
        drv(0, 0, 1, 0);
        #2;
        chk("byp_next_vld", vld_o, !BYP);
        chk("byp_next_cnt", cnt_o, BYP ? 0 : 1);
        if (!BYP) chk("byp_next_pc", pc_o, 32'h5000);
        next(); next();

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h6100 + 32'(4 * i), 0, 0);
            next();
        end
        drv(0, 0, 0, 0);
        #1;
        chk("pre_rst_cnt", cnt_o, 3);
        rst = 1'b1;
        #1;
        chk("rst_now_vld", vld_o, 0);
        chk("rst_now_rdy", rdy_o, 1);
        chk("rst_now_cnt", cnt_o, 0);
        chk("rst_now_pc", pc_o, 0);
        next();
        rst = 1'b0;
        drv(1, 32'h6000, 0, 0);
        next();
        drv(0, 0, 0, 0);
        #2;
        chk("post_rst_cnt", cnt_o, 1);
        chk("post_rst_pc", pc_o, 32'h6000);
        next();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            vld_i   = ($urandom_range(99) < 75);
            rdy_i   = ($urandom_range(99) < 55);
            flush   = ($urandom_range(99) < 5);
            pc_i    = $urandom;
            npc_i   = $urandom;
            instr_i = $urandom;
            is_c_i  = 1'($urandom);
            excp_i  = EWTH'($urandom);
            if ($urandom_range(999) < 3) begin
                #2;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            next();
        end

        drv(0, 0, 0, 0);
        next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
